stage_sequencer: RTL and testbench

Multi-cycle stage controller for the CPU core. It drives the STAGE value consumed by the register latch and the other per-stage blocks, and runs FETCH -> DECODE -> EXECUTE -> [MEMACCESS] -> MEMSTORE. It handshakes with instruction and data memory, bounds each memory wait with a timeout, and handles halt/resume. It also produces the register/PC write strobes and a retired-instruction counter.

---
 rtl/stage_sequencer_if.sv | 31 +++
 rtl/stage_sequencer.sv | 173 +++++++++++++++++
 tb/tb_stage_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/stage_sequencer_if.sv
// Control/handshake bundle between the stage sequencer and the core / memory side.
// The master is the sequencer. The slave is the decoder/memory environment that drives run, acks and decode flags.
interface stage_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic             resume;
    logic             imem_ack;
    logic             dmem_ack;
    logic             need_mem;
    logic             is_halt;
    logic [2:0]       stage;
    logic             imem_req;
    logic             dmem_req;
    logic             reg_we;
    logic             pc_we;
    logic             busy;
    logic             halted;
    logic             err;
    logic [CNT_W-1:0] retired;

    modport master (
        input  run, resume, imem_ack, dmem_ack, need_mem, is_halt,
        output stage, imem_req, dmem_req, reg_we, pc_we, busy, halted, err, retired
    );

    modport slave (
        output run, resume, imem_ack, dmem_ack, need_mem, is_halt,
        input  stage, imem_req, dmem_req, reg_we, pc_we, busy, halted, err, retired
    );
endinterface

// File: rtl/stage_sequencer.sv
// Multi-cycle CPU stage controller. All outputs are Moore-decoded from the state register, so they add no latency.
// Backpressure: FETCH and MEMACCESS wait on imem_ack/dmem_ack. A wait of MEM_TIMEOUT cycles without ack ends in sticky ERROR.
module stage_sequencer #(
    parameter int CNT_W       = 32,
    parameter int TMO_W       = 8,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    stage_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMACCESS,
        S_MEMSTORE,
        S_HALT,
        S_ERROR
    } state_t;

    localparam logic [2:0] STG_FETCH     = 3'd0;
    localparam logic [2:0] STG_DECODE    = 3'd1;
    localparam logic [2:0] STG_EXECUTE   = 3'd2;
    localparam logic [2:0] STG_MEMACCESS = 3'd3;
    localparam logic [2:0] STG_MEMSTORE  = 3'd4;
    localparam logic [2:0] STG_NONE      = 3'd7;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [TMO_W-1:0] wait_q, wait_d;
    logic             need_mem_q, need_mem_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic [2:0] stage;
    logic       imem_req;
    logic       dmem_req;
    logic       reg_we;
    logic       pc_we;
    logic       busy;
    logic       halted;
    logic       err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wait_q     <= '0;
            need_mem_q <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            need_mem_q <= need_mem_d;
            retired_q  <= retired_d;
        end
    end

    // Next-state logic; the wait counter restarts on every entry into a memory wait.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        need_mem_d = need_mem_q;
        retired_d  = retired_q;
        case (state_q)
            S_IDLE: begin
                if (bus.run) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end
            S_FETCH: begin
                if (bus.imem_ack) begin
                    state_d = S_DECODE;
                end else if (wait_q == TMO_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + TMO_W'(1);
                end
            end
            S_DECODE: begin
                need_mem_d = bus.need_mem;
                if (bus.is_halt) begin
                    state_d   = S_HALT;
                    retired_d = retired_q + CNT_W'(1);
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (need_mem_q) begin
                    state_d = S_MEMACCESS;
                    wait_d  = '0;
                end else begin
                    state_d = S_MEMSTORE;
                end
            end
            S_MEMACCESS: begin
                if (bus.dmem_ack) begin
                    state_d = S_MEMSTORE;
                end else if (wait_q == TMO_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + TMO_W'(1);
                end
            end
            S_MEMSTORE: begin
                retired_d = retired_q + CNT_W'(1);
                wait_d    = '0;
                state_d   = bus.run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                if (bus.resume) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
        endcase
    end

    always_comb begin
        stage    = STG_NONE;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        reg_we   = 1'b0;
        pc_we    = 1'b0;
        busy     = 1'b1;
        halted   = 1'b0;
        err      = 1'b0;
        case (state_q)
            S_IDLE:      busy = 1'b0;
            S_FETCH: begin
                stage    = STG_FETCH;
                imem_req = 1'b1;
            end
            S_DECODE:    stage = STG_DECODE;
            S_EXECUTE:   stage = STG_EXECUTE;
            S_MEMACCESS: begin
                stage    = STG_MEMACCESS;
                dmem_req = 1'b1;
            end
            S_MEMSTORE: begin
                stage  = STG_MEMSTORE;
                reg_we = 1'b1;
                pc_we  = 1'b1;
            end
            S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            S_ERROR: begin
                busy = 1'b0;
                err  = 1'b1;
            end
        endcase
    end

    assign bus.stage    = stage;
    assign bus.imem_req = imem_req;
    assign bus.dmem_req = dmem_req;
    assign bus.reg_we   = reg_we;
    assign bus.pc_we    = pc_we;
    assign bus.busy     = busy;
    assign bus.halted   = halted;
    assign bus.err      = err;
    assign bus.retired  = retired_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: a vector table, hand-written corner sequences, and a randomized run against a stage-level model.
module tb_stage_sequencer;
    localparam int CNT_W       = 4;
    localparam int TMO_W       = 8;
    localparam int MEM_TIMEOUT = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    stage_sequencer_if #(.CNT_W(CNT_W)) bus ();

    stage_sequencer #(
        .CNT_W      (CNT_W),
        .TMO_W      (TMO_W),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        bit run, rs, ia, da, nm, ih;
        int st, ret;
        bit hl, er;
    } vec_t;

    vec_t tbl[40];

    // Model of the sequencer: stage number plus halted/error flags.
    int m_st, m_wait, m_ret;
    bit m_hl, m_er, m_need;

    // Output vector: {stage, imem_req, dmem_req, reg_we, pc_we, busy, halted, err, retired}
    function automatic logic [13:0] pack_exp(int st, int ret, bit hl, bit er);
        logic [2:0] s;
        logic [3:0] r;
        s = 3'(st);
        r = 4'(ret % 16);
        return {s, st == 0, st == 3, st == 4, st == 4, st != 7, hl, er, r};
    endfunction

    function automatic logic [13:0] act_vec();
        return {bus.stage, bus.imem_req, bus.dmem_req, bus.reg_we, bus.pc_we,
                bus.busy, bus.halted, bus.err, bus.retired};
    endfunction

    task automatic chk(string nm, logic [13:0] exp);
        logic [13:0] a;
        a = act_vec();
        n_chk++;
        if (a === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (stage,ireq,dreq,rwe,pwe,busy,halt,err,ret)", nm, a, exp);
    endtask

    task automatic drive(bit run, bit rs, bit ia, bit da, bit nm, bit ih);
        bus.run      = run;
        bus.resume   = rs;
        bus.imem_ack = ia;
        bus.dmem_ack = da;
        bus.need_mem = nm;
        bus.is_halt  = ih;
    endtask

    function automatic vec_t mk(bit run, bit rs, bit ia, bit da, bit nm, bit ih,
                                int st, int ret, bit hl, bit er);
        vec_t v;
        v.run = run; v.rs = rs; v.ia = ia; v.da = da; v.nm = nm; v.ih = ih;
        v.st = st; v.ret = ret; v.hl = hl; v.er = er;
        return v;
    endfunction

    task automatic model_reset();
        m_st = 7; m_wait = 0; m_ret = 0; m_hl = 0; m_er = 0; m_need = 0;
    endtask

    task automatic model_step(bit run, bit rs, bit ia, bit da, bit nm, bit ih);
        if (m_er) return;
        if (m_hl) begin
            if (rs) begin m_hl = 0; m_st = 0; m_wait = 0; end
            return;
        end
        case (m_st)
            7: if (run) begin m_st = 0; m_wait = 0; end
            0: if (ia) m_st = 1;
               else begin
                   m_wait++;
                   if (m_wait == MEM_TIMEOUT) begin m_st = 7; m_er = 1; end
               end
            1: begin
                m_need = nm;
                if (ih) begin m_st = 7; m_hl = 1; m_ret = (m_ret + 1) % (1 << CNT_W); end
                else m_st = 2;
            end
            2: begin m_st = m_need ? 3 : 4; m_wait = 0; end
            3: if (da) m_st = 4;
               else begin
                   m_wait++;
                   if (m_wait == MEM_TIMEOUT) begin m_st = 7; m_er = 1; end
               end
            4: begin m_ret = (m_ret + 1) % (1 << CNT_W); m_st = run ? 0 : 7; m_wait = 0; end
            default: ;
        endcase
    endtask

    initial begin
        // Columns: run rs ia da nm ih | stage retired halted err
        for (int i = 0; i < 13; i++) begin
            int stg[4] = '{0, 1, 2, 4};
            if (i == 0) tbl[i] = mk(1,0,1,0,0,0, 7, 0, 0, 0);
            else        tbl[i] = mk(1,0,1,0,0,0, stg[(i-1)%4], (i-1)/4, 0, 0);
        end
        tbl[13] = mk(1,0,1,0,1,0, 0, 3, 0, 0);
        tbl[14] = mk(1,0,1,0,1,0, 1, 3, 0, 0);
        tbl[15] = mk(0,0,1,0,0,0, 2, 3, 0, 0);
        tbl[16] = mk(0,0,1,0,0,0, 3, 3, 0, 0);
        tbl[17] = mk(0,0,1,0,0,0, 3, 3, 0, 0);
        tbl[18] = mk(0,0,1,0,0,0, 3, 3, 0, 0);
        tbl[19] = mk(0,0,1,1,0,0, 3, 3, 0, 0);
        tbl[20] = mk(0,0,1,1,0,0, 4, 3, 0, 0);
        tbl[21] = mk(0,1,1,0,0,0, 7, 4, 0, 0);
        tbl[22] = mk(1,0,1,0,0,0, 7, 4, 0, 0);
        tbl[23] = mk(1,0,1,0,0,1, 0, 4, 0, 0);
        tbl[24] = mk(1,0,1,0,0,1, 1, 4, 0, 0);
        tbl[25] = mk(1,0,1,0,0,0, 7, 5, 1, 0);
        tbl[26] = mk(1,1,1,0,0,0, 7, 5, 1, 0);
        tbl[27] = mk(1,0,0,0,0,0, 0, 5, 0, 0);
        tbl[28] = mk(1,0,0,0,0,0, 0, 5, 0, 0);
        tbl[29] = mk(1,0,0,0,0,0, 0, 5, 0, 0);
        tbl[30] = mk(1,0,1,0,0,0, 0, 5, 0, 0);
        tbl[31] = mk(1,0,1,0,0,0, 1, 5, 0, 0);
        tbl[32] = mk(1,0,1,0,0,0, 2, 5, 0, 0);
        tbl[33] = mk(1,0,0,0,0,0, 4, 5, 0, 0);
        tbl[34] = mk(1,0,0,0,0,0, 0, 6, 0, 0);
        tbl[35] = mk(1,0,0,0,0,0, 0, 6, 0, 0);
        tbl[36] = mk(1,0,0,0,0,0, 0, 6, 0, 0);
        tbl[37] = mk(1,0,0,0,0,0, 0, 6, 0, 0);
        tbl[38] = mk(1,1,1,1,0,0, 7, 6, 0, 1);
        tbl[39] = mk(1,1,1,1,0,0, 7, 6, 0, 1);

        drive(0,0,0,0,0,0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_state", pack_exp(7, 0, 0, 0));
        reset = 1'b0;

        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("vec%0d", i), pack_exp(tbl[i].st, tbl[i].ret, tbl[i].hl, tbl[i].er));
            drive(tbl[i].run, tbl[i].rs, tbl[i].ia, tbl[i].da, tbl[i].nm, tbl[i].ih);
        end

        // Asynchronous reset in the middle of a data access.
        @(negedge clk);
        reset = 1'b1;
        drive(0,0,0,0,0,0);
        @(negedge clk);
        reset = 1'b0;
        drive(1,0,1,0,0,0);
        repeat (5) @(negedge clk);
        chk("arst_pre_fetch", pack_exp(0, 1, 0, 0));
        drive(1,0,1,0,1,0);
        repeat (3) @(negedge clk);
        chk("arst_pre_memaccess", pack_exp(3, 1, 0, 0));
        #1 reset = 1'b1;
        #1 chk("arst_immediate", pack_exp(7, 0, 0, 0));
        @(posedge clk);
        #1 chk("arst_held_edge", pack_exp(7, 0, 0, 0));
        @(negedge clk);
        reset = 1'b0;

        // Retired counter wraps after 16 instructions.
        drive(1,0,1,0,0,0);
        repeat (65) @(negedge clk);
        chk("wrap_16", pack_exp(0, 0, 0, 0));
        repeat (4) @(negedge clk);
        chk("wrap_17", pack_exp(0, 1, 0, 0));

        // Data-memory timeout: four MEMACCESS cycles without ack, then ERROR.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive(1,0,1,0,1,0);
        repeat (7) @(negedge clk);
        chk("dmem_tmo_last_wait", pack_exp(3, 0, 0, 0));
        @(negedge clk);
        chk("dmem_tmo_error", pack_exp(7, 0, 0, 1));

        // Randomized run against the model.
        reset = 1'b1;
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            bit run, rs, ia, da, nm, ih;
            @(negedge clk);
            chk("rand", pack_exp(m_st, m_ret, m_hl, m_er));
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(99) == 0 || (m_er && $urandom_range(3) == 0)) begin
                reset = 1'b1;
                model_reset();
                #1 chk("rand_arst", pack_exp(m_st, m_ret, m_hl, m_er));
                continue;
            end
            run = ($urandom_range(9) != 0);
            rs  = ($urandom_range(3) == 0);
            ia  = ($urandom_range(9) < 7);
            da  = ($urandom_range(9) < 7);
            nm  = $urandom_range(1) != 0;
            ih  = ($urandom_range(7) == 0);
            drive(run, rs, ia, da, nm, ih);
            model_step(run, rs, ia, da, nm, ih);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
